// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and constants for the data-memory copy engine.
//            Contains the engine state encoding, the default data/address
//            width and memory depth, and the idle write-data value that the
//            data memory expects on its WD lines when not being written.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int WIDTH = 16;
    localparam int DEPTH = 256;

    // The data memory qualifies reads on WD==1, so this value is driven
    // whenever the engine is not actively writing.
    localparam logic [15:0] DMEM_WD_IDLE = 16'h0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } dmem_state_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : dmem_copy_engine
// Purpose  : Memory-side initiator that copies len words from src to dst in
//            the single-port data memory with memmove semantics (backward
//            when the ranges overlap destructively). One RD cycle followed by
//            one WR cycle per word; a hold register carries the data.
// Ports    : clk, rst (async active-low)
//            start, src, dst, len   - request, sampled in IDLE
//            busy, done, err        - status
//            mem_A, mem_WD, mem_WE, mem_RE, mem_RD - memory port
// Revision : 1.0 - initial release
// ============================================================================
module dmem_copy_engine #(
    parameter int WIDTH = dmem_pkg::WIDTH,
    parameter int DEPTH = dmem_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] dst,
    input  logic [WIDTH-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] mem_A,
    output logic [WIDTH-1:0] mem_WD,
    output logic             mem_WE,
    output logic             mem_RE,
    input  logic [WIDTH-1:0] mem_RD
);
    import dmem_pkg::*;

    localparam logic [WIDTH-1:0] WD_IDLE = WIDTH'(DMEM_WD_IDLE);
    localparam logic [WIDTH:0]   DEPTH_X = (WIDTH+1)'(DEPTH);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    dmem_state_t      state;
    dmem_state_t      state_nxt;

    logic [WIDTH-1:0] src_q;
    logic [WIDTH-1:0] dst_q;
    logic [WIDTH-1:0] idx;
    logic [WIDTH-1:0] remain;
    logic [WIDTH-1:0] hold;
    logic             backward;
    logic             err_q;

    // Request decode, evaluated on the raw inputs while IDLE.
    logic [WIDTH:0]   src_end;
    logic [WIDTH:0]   dst_end;
    logic             range_bad;
    logic             len_zero;
    logic             go_backward;

    assign src_end     = {1'b0, src} + {1'b0, len};
    assign dst_end     = {1'b0, dst} + {1'b0, len};
    assign range_bad   = (src_end > DEPTH_X) || (dst_end > DEPTH_X);
    assign len_zero    = (len == '0);
    // Destination starts inside the source range above src: a forward copy
    // would overwrite source words before they are read.
    assign go_backward = (src < dst) && ({1'b0, dst} < src_end);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            idx      <= '0;
            remain   <= '0;
            hold     <= '0;
            backward <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        src_q    <= src;
                        dst_q    <= dst;
                        remain   <= len;
                        backward <= go_backward;
                        idx      <= go_backward ? (len - ONE) : '0;
                        // A zero-length request never reports a range error.
                        err_q    <= !len_zero && range_bad;
                    end
                end
                ST_RD: begin
                    hold <= mem_RD;
                end
                ST_WR: begin
                    idx    <= backward ? (idx - ONE) : (idx + ONE);
                    remain <= remain - ONE;
                end
                default: ;
            endcase
        end
    end

    // Next state and all memory strobes are decoded from the state register,
    // so an asynchronous reset drops the strobes immediately.
    always_comb begin
        state_nxt = state;
        mem_A     = '0;
        mem_WD    = WD_IDLE;
        mem_WE    = 1'b0;
        mem_RE    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (len_zero || range_bad) ? ST_DONE : ST_RD;
                end
            end
            ST_RD: begin
                mem_A     = src_q + idx;
                mem_RE    = 1'b1;
                state_nxt = ST_WR;
            end
            ST_WR: begin
                mem_A     = dst_q + idx;
                mem_WD    = hold;
                mem_WE    = 1'b1;
                state_nxt = (remain == ONE) ? ST_DONE : ST_RD;
            end
            ST_DONE: begin
                done      = 1'b1;
                err       = err_q;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule : dmem_copy_engine
`default_nettype wire

// File: tb/tb_dmem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_copy_engine
// Purpose  : Self-checking bench for dmem_copy_engine. A behavioural memory
//            answers the engine's port; expected writes (address, data) are
//            queued when a copy is launched and compared as writes appear.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_copy_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src, dst, len;
    logic        busy, done, err;
    logic [15:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE, mem_RE;

    always #5 clk = ~clk;

    dmem_copy_engine #(.WIDTH(16), .DEPTH(256)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .src    (src),
        .dst    (dst),
        .len    (len),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .mem_A  (mem_A),
        .mem_WD (mem_WD),
        .mem_WE (mem_WE),
        .mem_RE (mem_RE),
        .mem_RD (mem_RD)
    );

    logic [15:0] mem [0:255];
    assign mem_RD = (mem_A < 16'd256) ? mem[mem_A[7:0]] : 16'h0000;
    always @(posedge clk) begin
        if (mem_WE && mem_A < 16'd256) mem[mem_A[7:0]] <= mem_WD;
    end

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t exp_q[$];

    int          checks   = 0;
    int          failures = 0;
    int          re_cnt   = 0;
    int          we_cnt   = 0;
    logic [15:0] first_wa = '0;
    logic [15:0] last_wa  = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor / scoreboard consumer.
    always @(negedge clk) begin
        wr_t e;
        if (mem_WE || mem_RE) check_eq("strobe_exclusive", {31'b0, mem_WE & mem_RE}, 32'd0);
        if (mem_RE) re_cnt++;
        if (mem_WE) begin
            if (we_cnt == 0) first_wa = mem_A;
            last_wa = mem_A;
            we_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("write_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_addr", {16'h0, mem_A},  {16'h0, e.a});
                check_eq("wr_data", {16'h0, mem_WD}, {16'h0, e.d});
            end
        end
    end

    // Queue the expected write sequence from a plain memmove model.
    task automatic push_expected(input int s, input int d, input int l);
        bit bw;
        int ix;
        if (l == 0 || s + l > 256 || d + l > 256) return;
        bw = (s < d) && (d < s + l);
        for (int i = 0; i < l; i++) begin
            ix = bw ? (l - 1 - i) : i;
            exp_q.push_back({16'(d + ix), mem[s + ix]});
        end
    endtask

    // Launch a copy in cycle 0 and observe a fixed window. restart>0 pulses a
    // second start in that cycle.
    task automatic run_copy(input int s, input int d, input int l, input int restart,
                            output int done_cyc, output logic err_seen, output int n_done);
        push_expected(s, d, l);
        re_cnt   = 0;
        we_cnt   = 0;
        done_cyc = -1;
        err_seen = 1'b0;
        n_done   = 0;
        @(negedge clk);
        start = 1'b1; src = 16'(s); dst = 16'(d); len = 16'(l);
        for (int k = 1; k <= 2 * l + 8; k++) begin
            @(negedge clk);
            start = (k == restart);
            if (k == restart) begin
                src = 16'd60; dst = 16'd50; len = 16'd1;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    err_seen = err;
                    check_eq("busy_at_done", {31'b0, busy}, 32'd1);
                end
            end
        end
        start = 1'b0;
        if (done_cyc < 0) check_eq("done_timeout", 32'hFFFF_FFFF, 32'(2 * l + 1));
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        check_eq("idle_after", {31'b0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, {31'b0, busy},   32'd0);
        check_eq({tag, "_done"}, {31'b0, done},   32'd0);
        check_eq({tag, "_err"},  {31'b0, err},    32'd0);
        check_eq({tag, "_we"},   {31'b0, mem_WE}, 32'd0);
        check_eq({tag, "_re"},   {31'b0, mem_RE}, 32'd0);
        check_eq({tag, "_a"},    {16'h0, mem_A},  32'd0);
        check_eq({tag, "_wd"},   {16'h0, mem_WD}, 32'd1);
    endtask

    initial begin
        int   dc, nd;
        logic es;
        logic [15:0] snap;

        rst = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 7 + 3);
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Forward, non-overlapping.
        mem[10] = 16'hAAAA; mem[11] = 16'hBBBB; mem[12] = 16'hCCCC;
        run_copy(10, 20, 3, 0, dc, es, nd);
        check_eq("fwd_done_cyc", 32'(dc), 32'd7);
        check_eq("fwd_err", {31'b0, es}, 32'd0);
        check_eq("fwd_re_cnt", 32'(re_cnt), 32'd3);
        check_eq("fwd_we_cnt", 32'(we_cnt), 32'd3);
        check_eq("fwd_m20", {16'h0, mem[20]}, 32'hAAAA);
        check_eq("fwd_m21", {16'h0, mem[21]}, 32'hBBBB);
        check_eq("fwd_m22", {16'h0, mem[22]}, 32'hCCCC);

        // Overlap, must run backward.
        for (int i = 0; i < 4; i++) mem[10 + i] = 16'(i + 1);
        run_copy(10, 11, 4, 0, dc, es, nd);
        check_eq("bwd_done_cyc", 32'(dc), 32'd9);
        check_eq("bwd_first_wa", {16'h0, first_wa}, 32'd14);
        check_eq("bwd_last_wa",  {16'h0, last_wa},  32'd11);
        for (int i = 0; i < 4; i++)
            check_eq("bwd_mem", {16'h0, mem[11 + i]}, 32'(i + 1));

        // Overlap with dst below src, forward is safe.
        for (int i = 0; i < 4; i++) mem[11 + i] = 16'(i + 5);
        run_copy(11, 10, 4, 0, dc, es, nd);
        check_eq("ofwd_first_wa", {16'h0, first_wa}, 32'd10);
        check_eq("ofwd_last_wa",  {16'h0, last_wa},  32'd13);
        for (int i = 0; i < 4; i++)
            check_eq("ofwd_mem", {16'h0, mem[10 + i]}, 32'(i + 5));

        // Zero length.
        run_copy(5, 30, 0, 0, dc, es, nd);
        check_eq("zero_done_cyc", 32'(dc), 32'd1);
        check_eq("zero_err", {31'b0, es}, 32'd0);
        check_eq("zero_strobes", 32'(re_cnt + we_cnt), 32'd0);

        // Range error on source end.
        snap = mem[0];
        run_copy(250, 0, 10, 0, dc, es, nd);
        check_eq("rerr_done_cyc", 32'(dc), 32'd1);
        check_eq("rerr_err", {31'b0, es}, 32'd1);
        check_eq("rerr_we_cnt", 32'(we_cnt), 32'd0);
        check_eq("rerr_mem_unchanged", {16'h0, mem[0]}, {16'h0, snap});

        // Range error on destination end, boundary exactly one over.
        run_copy(0, 253, 4, 0, dc, es, nd);
        check_eq("derr_err", {31'b0, es}, 32'd1);
        check_eq("derr_we_cnt", 32'(we_cnt), 32'd0);

        // Exactly at the top of memory is legal.
        mem[0] = 16'h1234; mem[1] = 16'h5678;
        run_copy(0, 254, 2, 0, dc, es, nd);
        check_eq("edge_err", {31'b0, es}, 32'd0);
        check_eq("edge_m255", {16'h0, mem[255]}, 32'h5678);

        // Start while busy is ignored.
        mem[30] = 16'h1111; mem[31] = 16'h2222; snap = mem[50];
        run_copy(30, 40, 2, 3, dc, es, nd);
        check_eq("busy_done_cyc", 32'(dc), 32'd5);
        check_eq("busy_n_done", 32'(nd), 32'd1);
        check_eq("busy_m41", {16'h0, mem[41]}, 32'h2222);
        check_eq("busy_m50_unchanged", {16'h0, mem[50]}, {16'h0, snap});

        // Reset in the middle of the second word's WR cycle.
        for (int i = 0; i < 4; i++) mem[i] = 16'(16'hC0 + i);
        mem[100] = 16'hDEAD; mem[101] = 16'hBEEF;
        push_expected(0, 100, 4);
        @(negedge clk);
        start = 1'b1; src = 16'd0; dst = 16'd100; len = 16'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rmid_we_before", {31'b0, mem_WE}, 32'd1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("rmid");
        @(posedge clk);
        #1;
        check_eq("rmid_m100", {16'h0, mem[100]}, 32'h00C0);
        check_eq("rmid_m101", {16'h0, mem[101]}, 32'hBEEF);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rmid_no_done", {31'b0, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dmem_copy_engine
`default_nettype wire
